mem_refill_arbiter: RTL
=======================

Name: mem_refill_arbiter

Overview:
Parametrised successor to the single-port miss path in the memory subsystem. Arbitrates cache-miss refill requests from NUM_CH requesters (ch0 = L1I, ch1 = L1D, further channels reserved for future DMA/video-LUT fetch) onto one backing-store port (the SPI flash controller). Returns refill data to the winning requester with a one-cycle valid pulse. Generates the pipeline stall, and enforces a response timeout so a hung flash cannot lock the CPU.

Parameters:
NUM_CH, 2, number of requesting channels (1..8)
ADDR_W, 20, request address width (physical flash window)
DATA_W, 32, refill word width
TIMEOUT_CYC, 4096, max cycles waiting for mem_ready; 0 disables the timeout

Ports:
CLK_CPU  input  1  CPU clock; all state changes on its rising edge
resetp  input  1  reset, synchronous, active-high
ch_req  input  NUM_CH  per-channel refill request (level, held until served)
ch_addr  input  NUM_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
ch_resp_valid  output  NUM_CH  one-hot, one-cycle pulse: refill word for channel i is valid
ch_rdata  output  DATA_W  refill word, shared by all channels, qualified by ch_resp_valid
ch_err  output  1  response is a timeout error (qualified by ch_resp_valid)
mem_valid  output  1  request to backing store
mem_addr  output  ADDR_W  backing-store address
mem_accept  input  1  backing store has taken the request
mem_ready  input  1  one-cycle pulse: mem_rdata valid
mem_rdata  input  DATA_W  backing-store read word
busy  output  1  arbiter is not IDLE
stall  output  1  pipeline stall: any ch_req high OR busy (combinational)

Behaviour:
- Clock/reset: one clock, CLK_CPU; reset resetp is synchronous and active-high.
- Reset state: IDLE.
  - Reset values: ch_resp_valid=0, ch_rdata=0, ch_err=0, mem_valid=0, mem_addr=0, busy=0.
  - Reset also clears the grant register, the rr pointer (0), the timeout counter and the mask flag.
  - Reset asserted mid-transaction: abort immediately. No resp pulse is produced; mem_valid drops the next cycle.
- All outputs except stall are registered.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If any unmasked ch_req is high, the winner (see arbitration) is latched into grant and its address into mem_addr. Next state is REQ.
  - mem_valid is 1 from REQ entry.
- REQ:
  - mem_valid=1 and mem_addr is held stable.
  - On mem_accept=1: go to WAIT, clear the timeout counter, drop mem_valid.
  - No timeout applies in REQ.
- WAIT:
  - On mem_ready=1: latch mem_rdata into ch_rdata, set ch_err=0, go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYC-1 (and TIMEOUT_CYC≠0): set ch_rdata=0, ch_err=1, go to DONE.
  - If mem_ready arrives in the same cycle as the timeout, mem_ready wins.
- DONE:
  - ch_resp_valid[grant]=1 for exactly one cycle, then IDLE.
  - On entering IDLE, a mask flag blocks the just-served channel for one cycle. This lets the requester drop ch_req after the fill without causing a duplicate refill.
- Minimum latency: ch_req rising to ch_resp_valid takes 4 cycles (mem_accept in the first REQ cycle, mem_ready in the first WAIT cycle).
- A request that drops ch_req while granted is still completed, and its resp pulse is still delivered.
- mem_ready arriving outside WAIT is ignored.
- ch_addr changes after grant are ignored.
- Arbitration (default, without macro): fixed priority, lowest index wins. ch0 (instruction fetch) beats ch1.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - rr pointer = last granted index + 1, mod NUM_CH.
  - Search from the pointer upward with wrap-around; the first requesting channel wins.
  - The pointer updates only on a grant.
- Not defined: fixed priority as above. No pointer register is synthesised.

Test Plan:
- Single request: ch_req=01, ch_addr0=0x00404, mem_accept the same cycle, mem_ready 3 cycles later with 0xDEADBEEF. Required: mem_addr=0x00404, ch_resp_valid=01 for one cycle, ch_rdata=0xDEADBEEF, ch_err=0, stall high throughout and low the cycle after ch_req drops.
- Collision: ch_req=11 in the same cycle, addr0=0x00100, addr1=0x000AF010, both held. Without the macro: ch0 served first, then ch1 (mem_addr sequence 0x00100, 0xAF010). With ARB_ROUND_ROBIN_EN and pointer=1: ch1 is served first.
- Round-robin fairness (macro on, NUM_CH=4): all ch_req held high for 8 refills. Required grant order 0,1,2,3,0,1,2,3.
- Timeout: TIMEOUT_CYC=16, mem_accept given, mem_ready never given. Required: exactly 16 WAIT cycles, then ch_resp_valid pulse with ch_err=1 and ch_rdata=0, then return to IDLE.
- Reset mid-WAIT: assert resetp for 1 cycle during WAIT. Required: next cycle state IDLE, busy=0, mem_valid=0, no ch_resp_valid. A later mem_ready pulse is ignored.
- Backpressure: mem_accept held low for 10 cycles. Required: mem_valid and mem_addr stable for all 10 cycles, no timeout counted, and completion after acceptance.

Source files
------------

// File: rtl/mem_refill_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_refill_arbiter_if: requester-side and backing-store signals of the arbiter
// rev 1.0
// ============================================================================
interface mem_refill_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
);
   logic [NUM_CH-1:0]        ch_req;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH-1:0]        ch_resp_valid;
   logic [DATA_W-1:0]        ch_rdata;
   logic                     ch_err;
   logic                     mem_valid;
   logic [ADDR_W-1:0]        mem_addr;
   logic                     mem_accept;
   logic                     mem_ready;
   logic [DATA_W-1:0]        mem_rdata;
   logic                     busy;
   logic                     stall;

   modport master (
      input  ch_req, ch_addr, mem_accept, mem_ready, mem_rdata,
      output ch_resp_valid, ch_rdata, ch_err, mem_valid, mem_addr, busy, stall
   );

   modport slave (
      output ch_req, ch_addr, mem_accept, mem_ready, mem_rdata,
      input  ch_resp_valid, ch_rdata, ch_err, mem_valid, mem_addr, busy, stall
   );
endinterface
`default_nettype wire

// File: rtl/mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// mem_refill_arbiter: arbitrates cache refills from NUM_CH requesters onto one
// flash port; define ARB_ROUND_ROBIN_EN for round-robin arbitration. rev 1.0
// ============================================================================
module mem_refill_arbiter #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 4096
) (
   input  wire logic            CLK_CPU,
   input  wire logic            resetp,
   mem_refill_arbiter_if.master bus
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [IDX_W-1:0]    grant, grant_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                mask, mask_nx;
   logic [NUM_CH-1:0]   resp_valid, resp_nx;
   logic [DATA_W-1:0]   rdata, rdata_nx;
   logic                err, err_nx;
   logic                mem_valid, mem_valid_nx;
   logic [ADDR_W-1:0]   mem_addr, addr_nx;
   logic                busy, busy_nx;
   logic [NUM_CH-1:0]   req_eff;
   logic                win_found;
   logic [IDX_W-1:0]    win;
`ifdef ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0]    rr, rr_nx;
`endif

   always_comb begin
      req_eff = bus.ch_req;
      // the channel just served sits out one IDLE cycle so it can drop its request
      if (mask) req_eff[grant] = 1'b0;
      win_found = 1'b0;
      win       = '0;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NUM_CH; k++) begin
         if (!win_found && req_eff[(k + int'(rr)) % NUM_CH]) begin
            win_found = 1'b1;
            win       = IDX_W'((k + int'(rr)) % NUM_CH);
         end
      end
`else
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req_eff[i]) begin
            win_found = 1'b1;
            win       = IDX_W'(i);
         end
      end
`endif
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      cnt_nx   = cnt;
      addr_nx  = mem_addr;
      rdata_nx = rdata;
      err_nx   = err;
`ifdef ARB_ROUND_ROBIN_EN
      rr_nx    = rr;
`endif
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nx = REQ;
               grant_nx = win;
               addr_nx  = bus.ch_addr[win*ADDR_W +: ADDR_W];
`ifdef ARB_ROUND_ROBIN_EN
               rr_nx    = (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
`endif
            end
         end
         REQ: begin
            if (bus.mem_accept) begin
               state_nx = WAIT;
               cnt_nx   = '0;
            end
         end
         WAIT: begin
            if (bus.mem_ready) begin
               state_nx = DONE;
               rdata_nx = bus.mem_rdata;
               err_nx   = 1'b0;
            end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
               state_nx = DONE;
               rdata_nx = '0;
               err_nx   = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      resp_nx = '0;
      if (state_nx == DONE) resp_nx[grant] = 1'b1;
      mask_nx      = (state == DONE);
      mem_valid_nx = (state_nx == REQ);
      busy_nx      = (state_nx != IDLE);
   end

   always_ff @(posedge CLK_CPU) begin
      if (resetp) begin
         state      <= IDLE;
         grant      <= '0;
         cnt        <= '0;
         mask       <= 1'b0;
         resp_valid <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         busy       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         rr         <= '0;
`endif
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         cnt        <= cnt_nx;
         mask       <= mask_nx;
         resp_valid <= resp_nx;
         rdata      <= rdata_nx;
         err        <= err_nx;
         mem_valid  <= mem_valid_nx;
         mem_addr   <= addr_nx;
         busy       <= busy_nx;
`ifdef ARB_ROUND_ROBIN_EN
         rr         <= rr_nx;
`endif
      end
   end

   assign bus.ch_resp_valid = resp_valid;
   assign bus.ch_rdata      = rdata;
   assign bus.ch_err        = err;
   assign bus.mem_valid     = mem_valid;
   assign bus.mem_addr      = mem_addr;
   assign bus.busy          = busy;
   assign bus.stall         = (|bus.ch_req) | busy;
endmodule
`default_nettype wire
